// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/done handshake: single-cycle arithmetic and logic ops,
// bit-serial shift/rotate and shift-add multiply. Flags use x86 FLAGS bit positions.
//
// state | meaning
// IDLE  | waiting for start; last result held on the outputs
// EXEC  | single-cycle op, result already registered, done asserted
// SHIFT | one shift/rotate step per cycle until the counter reaches 0
// MUL   | one shift-add step per cycle, N steps
module seq_alu #(
    parameter int WIDTH    = 16,
    parameter int CNT_BITS = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [3:0]          op,
    input  logic                is_8_bit,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [CNT_BITS-1:0] count,
    input  logic [15:0]         flags_in,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    out,
    output logic [WIDTH-1:0]    out_hi,
    output logic [15:0]         flags_out
);

    localparam int CW = (CNT_BITS > $clog2(WIDTH + 1)) ? CNT_BITS : $clog2(WIDTH + 1);

    localparam logic [3:0] OP_SELA = 4'd0;
    localparam logic [3:0] OP_SELB = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_ADC  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_SBB  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SAR  = 4'd11;
    localparam logic [3:0] OP_ROL  = 4'd12;
    localparam logic [3:0] OP_ROR  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_MUL} state_t;

    function automatic logic [WIDTH-1:0] nmask(input logic n8);
        return n8 ? WIDTH'(8'hFF) : {WIDTH{1'b1}};
    endfunction

    function automatic logic [WIDTH-1:0] top_bit(input logic n8);
        return n8 ? WIDTH'(8'h80) : (WIDTH'(1) << (WIDTH - 1));
    endfunction

    function automatic logic msb(input logic [WIDTH-1:0] v, input logic n8);
        return n8 ? v[7] : v[WIDTH-1];
    endfunction

    function automatic logic msb2(input logic [WIDTH-1:0] v, input logic n8);
        return n8 ? v[6] : v[WIDTH-2];
    endfunction

    // PF/ZF/SF come from the result; CF/AF/OF are supplied by the op.
    function automatic logic [15:0] arith_flags(input logic [15:0] base,
                                                input logic [WIDTH-1:0] res,
                                                input logic n8,
                                                input logic cf,
                                                input logic af,
                                                input logic of);
        logic [15:0] f;
        f     = base;
        f[0]  = cf;
        f[2]  = ~^res[7:0];
        f[4]  = af;
        f[6]  = ((res & nmask(n8)) == '0);
        f[7]  = msb(res, n8);
        f[11] = of;
        return f;
    endfunction

    function automatic logic is_shift_op(input logic [3:0] o);
        return (o >= OP_SHL) && (o <= OP_ROR);
    endfunction

    state_t             state_q, state_n;
    logic               accept;

    logic [3:0]         op_q;
    logic               n8_q;
    logic [15:0]        fl_q;
    logic               a_msb_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   sh_q;
    logic [2*WIDTH-1:0] mc_q;
    logic [WIDTH-1:0]   mp_q;
    logic [2*WIDTH-1:0] prod_q;

    logic [WIDTH-1:0]   out_q, hi_q;
    logic [15:0]        flags_q;

    logic [WIDTH-1:0]   ex_m, ex_am, ex_bm, ex_res;
    logic               ex_cin, ex_cy;
    logic [WIDTH:0]     ex_sum, ex_dif;
    logic [15:0]        ex_flags;

    logic [WIDTH-1:0]   sh_m, sh_n;
    logic               sh_cf;
    logic [15:0]        sh_flags;

    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH-1:0]   mul_lo, mul_hi;
    logic [15:0]        mul_flags;

    assign accept = start && (state_q == S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_n = S_MUL;
                    end else if (is_shift_op(op) && (count != '0)) begin
                        state_n = S_SHIFT;
                    end else begin
                        state_n = S_EXEC;
                    end
                end
            end
            S_EXEC:  state_n = S_IDLE;
            S_SHIFT: if (cnt_q == '0) state_n = S_IDLE;
            S_MUL:   if (cnt_q == '0) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = 1'b0;
        case (state_q)
            S_EXEC:         done = 1'b1;
            S_SHIFT, S_MUL: done = (cnt_q == '0);
            default:        done = 1'b0;
        endcase
    end

    // Single-cycle ops are evaluated from the live inputs at the accepting edge.
    always_comb begin
        ex_m     = nmask(is_8_bit);
        ex_am    = a & ex_m;
        ex_bm    = b & ex_m;
        ex_cin   = flags_in[0] & ((op == OP_ADC) || (op == OP_SBB));
        ex_sum   = {1'b0, ex_am} + {1'b0, ex_bm} + (WIDTH + 1)'(ex_cin);
        ex_dif   = {1'b0, ex_am} - {1'b0, ex_bm} - (WIDTH + 1)'(ex_cin);
        ex_res   = ex_am;
        ex_cy    = 1'b0;
        ex_flags = flags_in;
        case (op)
            OP_SELB: ex_res = ex_bm;
            OP_ADD, OP_ADC: begin
                ex_res   = ex_sum[WIDTH-1:0] & ex_m;
                ex_cy    = is_8_bit ? ex_sum[8] : ex_sum[WIDTH];
                ex_flags = arith_flags(flags_in, ex_res, is_8_bit, ex_cy,
                                       a[4] ^ b[4] ^ ex_res[4],
                                       ~msb(a ^ b, is_8_bit) & msb(ex_res ^ a, is_8_bit));
            end
            OP_SUB, OP_SBB: begin
                ex_res   = ex_dif[WIDTH-1:0] & ex_m;
                ex_cy    = is_8_bit ? ex_dif[8] : ex_dif[WIDTH];
                ex_flags = arith_flags(flags_in, ex_res, is_8_bit, ex_cy,
                                       a[4] ^ b[4] ^ ex_res[4],
                                       msb(a ^ b, is_8_bit) & msb(ex_res ^ a, is_8_bit));
            end
            OP_AND: begin
                ex_res   = ex_am & ex_bm;
                ex_flags = arith_flags(flags_in, ex_res, is_8_bit, 1'b0, 1'b0, 1'b0);
            end
            OP_OR: begin
                ex_res   = ex_am | ex_bm;
                ex_flags = arith_flags(flags_in, ex_res, is_8_bit, 1'b0, 1'b0, 1'b0);
            end
            OP_XOR: begin
                ex_res   = ex_am ^ ex_bm;
                ex_flags = arith_flags(flags_in, ex_res, is_8_bit, 1'b0, 1'b0, 1'b0);
            end
            default: begin
                ex_res   = ex_am;
                ex_flags = flags_in;
            end
        endcase
    end

    // One shift/rotate step; the flags are only latched on the final step.
    always_comb begin
        sh_m     = nmask(n8_q);
        sh_n     = sh_q;
        sh_cf    = 1'b0;
        sh_flags = fl_q;
        case (op_q)
            OP_SHL: begin
                sh_cf    = msb(sh_q, n8_q);
                sh_n     = (sh_q << 1) & sh_m;
                sh_flags = arith_flags(fl_q, sh_n, n8_q, sh_cf, 1'b0, msb(sh_n, n8_q) ^ sh_cf);
            end
            OP_SHR: begin
                sh_cf    = sh_q[0];
                sh_n     = sh_q >> 1;
                sh_flags = arith_flags(fl_q, sh_n, n8_q, sh_cf, 1'b0, a_msb_q);
            end
            OP_SAR: begin
                sh_cf    = sh_q[0];
                sh_n     = (sh_q >> 1) | (msb(sh_q, n8_q) ? top_bit(n8_q) : '0);
                sh_flags = arith_flags(fl_q, sh_n, n8_q, sh_cf, 1'b0, 1'b0);
            end
            OP_ROL: begin
                sh_n     = ((sh_q << 1) & sh_m) | WIDTH'(msb(sh_q, n8_q));
                sh_cf    = sh_n[0];
                sh_flags = fl_q;
                sh_flags[0]  = sh_cf;
                sh_flags[11] = msb(sh_n, n8_q) ^ sh_cf;
            end
            OP_ROR: begin
                sh_n     = (sh_q >> 1) | (sh_q[0] ? top_bit(n8_q) : '0);
                sh_cf    = msb(sh_n, n8_q);
                sh_flags = fl_q;
                sh_flags[0]  = sh_cf;
                sh_flags[11] = msb(sh_n, n8_q) ^ msb2(sh_n, n8_q);
            end
            default: begin
                sh_n     = sh_q;
                sh_flags = fl_q;
            end
        endcase
    end

    always_comb begin
        prod_n    = prod_q + (mp_q[0] ? mc_q : '0);
        mul_lo    = n8_q ? WIDTH'(prod_n[7:0])  : prod_n[WIDTH-1:0];
        mul_hi    = n8_q ? WIDTH'(prod_n[15:8]) : prod_n[2*WIDTH-1:WIDTH];
        mul_flags = arith_flags(fl_q, mul_lo, n8_q, mul_hi != '0, 1'b0, mul_hi != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            n8_q    <= 1'b0;
            fl_q    <= '0;
            a_msb_q <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            prod_q  <= '0;
            out_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else if (accept) begin
            op_q    <= op;
            n8_q    <= is_8_bit;
            fl_q    <= flags_in;
            a_msb_q <= msb(a, is_8_bit);
            sh_q    <= a & nmask(is_8_bit);
            mc_q    <= {{WIDTH{1'b0}}, a & nmask(is_8_bit)};
            mp_q    <= b & nmask(is_8_bit);
            prod_q  <= '0;
            if (op == OP_MUL) begin
                cnt_q <= is_8_bit ? CW'(8) : CW'(WIDTH);
            end else begin
                cnt_q <= CW'(count);
            end
            if (state_n == S_EXEC) begin
                out_q   <= ex_res;
                hi_q    <= '0;
                flags_q <= ex_flags;
            end
        end else if ((state_q == S_SHIFT) && (cnt_q != '0)) begin
            sh_q  <= sh_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                out_q   <= sh_n;
                hi_q    <= '0;
                flags_q <= sh_flags;
            end
        end else if ((state_q == S_MUL) && (cnt_q != '0)) begin
            prod_q <= prod_n;
            mc_q   <= mc_q << 1;
            mp_q   <= mp_q >> 1;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                out_q   <= mul_lo;
                hi_q    <= mul_hi;
                flags_q <= mul_flags;
            end
        end
    end

    assign out       = out_q;
    assign out_hi    = hi_q;
    assign flags_out = flags_q;

endmodule
